// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: access size encodings and
// the bus-handshake state machine states.
package dmem_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } busStateT;

endpackage

// File: rtl/dmem_bridge_mem_lane.sv
// Byte-lane steering: replicates store data across the bus word and extracts
// and extends the addressed lane of a load word.
module mem_lane
  import dmem_bridge_pkg::*;
(
  input  logic [1:0]  wrSize,
  input  logic [31:0] wrData,
  input  logic [1:0]  rdSize,
  input  logic        rdSign,
  input  logic [1:0]  rdOffset,
  input  logic [31:0] rdRaw,
  output logic [31:0] laneWdata,
  output logic [31:0] loadData
);

  logic [7:0]  rdByte;
  logic [15:0] rdHalf;

  always_comb begin
    laneWdata = wrData;
    case (wrSize)
      SZ_BYTE: laneWdata = {4{wrData[7:0]}};
      SZ_HALF: laneWdata = {2{wrData[15:0]}};
      default: laneWdata = wrData;
    endcase
  end

  // Size code 11 falls through to the word path on both sides.
  always_comb begin
    rdByte   = rdRaw[7:0];
    rdHalf   = rdOffset[1] ? rdRaw[31:16] : rdRaw[15:0];
    loadData = rdRaw;
    case (rdOffset)
      2'd0:    rdByte = rdRaw[7:0];
      2'd1:    rdByte = rdRaw[15:8];
      2'd2:    rdByte = rdRaw[23:16];
      default: rdByte = rdRaw[31:24];
    endcase
    case (rdSize)
      SZ_BYTE: loadData = {{24{rdSign & rdByte[7]}}, rdByte};
      SZ_HALF: loadData = {{16{rdSign & rdHalf[15]}}, rdHalf};
      default: loadData = rdRaw;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the M-stage memory access onto an addr_ok/data_ok split bus,
// stalling the pipeline until the single outstanding transaction completes.
module dmem_bridge
  import dmem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  memsizeM,
  input  logic        memsignM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  busStateT    state, nextState;
  logic        misaligned, go;
  logic        ldSign;
  logic [1:0]  ldSize, ldOffset;
  logic [31:0] laneWdata, loadData;

  assign misaligned = ((memsizeM == SZ_HALF) & addrM[0]) | (memsizeM[1] & (addrM[1:0] != 2'b00));
  assign adelM      = memenM & ~memwriteM & misaligned;
  assign adesM      = memenM & memwriteM & misaligned;
  assign go         = memenM & ~misaligned;

  mem_lane uLane (
    .wrSize    (memsizeM),
    .wrData    (writedataM),
    .rdSize    (ldSize),
    .rdSign    (ldSign),
    .rdOffset  (ldOffset),
    .rdRaw     (data_rdata),
    .laneWdata (laneWdata),
    .loadData  (loadData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (go) nextState = ADDR;
      ADDR:    if (data_addr_ok) nextState = DATA;
      DATA:    if (data_data_ok) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  assign data_req = (state == ADDR);
  assign stallM   = ((state == IDLE) & go) | (state == ADDR) | (state == DATA);

  // Bus request fields are only loaded on IDLE->ADDR, so they stay stable while data_req is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_wr    <= 1'b0;
      data_size  <= 2'b00;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      ldSign     <= 1'b0;
      ldSize     <= 2'b00;
      ldOffset   <= 2'b00;
      readdataM  <= 32'h0;
    end else begin
      if ((state == IDLE) && go) begin
        data_wr    <= memwriteM;
        data_size  <= memsizeM;
        data_addr  <= addrM;
        data_wdata <= laneWdata;
        ldSign     <= memsignM;
        ldSize     <= memsizeM;
        ldOffset   <= addrM[1:0];
      end
      if ((state == DATA) && data_data_ok && !data_wr) readdataM <= loadData;
    end
  end

endmodule
